// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter: merges one ALU and one load-result stream into a single register file
// write port, with a one-entry ALU holding register and a per-register pending-write scoreboard.
module scalar_wb_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_dst,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_dst,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dst,
  output logic                     issue_stall,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_dst,
  output logic [DATA_W-1:0]        wr_data,
  output logic [7:0]               wb_count
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic                hold_valid;
  logic [ADDR_W-1:0]   hold_dst;
  logic [DATA_W-1:0]   hold_data;

  logic                alu_accept;
  logic                hold_load;
  logic                hold_clear;
  logic                sel_en;
  logic [ADDR_W-1:0]   sel_dst;
  logic [DATA_W-1:0]   sel_data;
  logic [NumRegs-1:0]  busy_set;
  logic [NumRegs-1:0]  busy_clr;

  assign alu_ready   = ~hold_valid;
  assign alu_accept  = alu_valid & alu_ready;
  assign issue_stall = issue_valid & busy[issue_dst];

  // Loads never stall, so an ALU result arriving alongside one is parked in the hold.
  always_comb begin
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    sel_en     = 1'b0;
    sel_dst    = '0;
    sel_data   = '0;
    if (mem_valid) begin
      sel_en    = 1'b1;
      sel_dst   = mem_dst;
      sel_data  = mem_data;
      hold_load = alu_accept;
    end else if (hold_valid) begin
      sel_en     = 1'b1;
      sel_dst    = hold_dst;
      sel_data   = hold_data;
      hold_clear = 1'b1;
    end else if (alu_accept) begin
      sel_en   = 1'b1;
      sel_dst  = alu_dst;
      sel_data = alu_data;
    end
  end

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (issue_valid && !issue_stall) busy_set[issue_dst] = 1'b1;
    if (sel_en)                      busy_clr[sel_dst]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_dst   <= '0;
      hold_data  <= '0;
      wr_en      <= 1'b0;
      wr_dst     <= '0;
      wr_data    <= '0;
      wb_count   <= '0;
      busy       <= '0;
    end else begin
      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_dst   <= alu_dst;
        hold_data  <= alu_data;
      end else if (hold_clear) begin
        hold_valid <= 1'b0;
      end
      wr_en <= sel_en;
      if (sel_en) begin
        wr_dst   <= sel_dst;
        wr_data  <= sel_data;
        wb_count <= wb_count + 8'd1;
      end
      // A new reservation wins over a commit clearing the same bit.
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed self-checking bench for scalar_wb_arbiter; inputs change and outputs are sampled
// 1ns after each rising edge.
module tb_scalar_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [3:0]  alu_dst;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_dst;
  logic [15:0] mem_data;
  logic        issue_valid;
  logic [3:0]  issue_dst;
  logic        issue_stall;
  logic [15:0] busy;
  logic        wr_en;
  logic [3:0]  wr_dst;
  logic [15:0] wr_data;
  logic [7:0]  wb_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_count;

  scalar_wb_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_stall(issue_stall),
    .busy(busy), .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_dst = '0; alu_data = '0;
    mem_valid = 0; mem_dst = '0; mem_data = '0;
    issue_valid = 0; issue_dst = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #2;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (wr_dst !== 4'd0) begin errors++; $display("FAIL reset_wr_dst got %h want 0", wr_dst); end
    checks++; if (wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    checks++; if (busy !== 16'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
    checks++; if (wb_count !== 8'd0) begin errors++; $display("FAIL reset_wb_count got %0d want 0", wb_count); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b want 1", alu_ready); end
    tick(); tick();
    rst_n = 1;
    exp_count = 8'd0;
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL post_release_idle got %b want 0", wr_en); end
  endtask

  task automatic test_alu_only();
    alu_valid = 1; alu_dst = 4'd3; alu_data = 16'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready_empty got %b want 1", alu_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL alu_latency got %b want 0", wr_en); end
    tick();
    idle_inputs();
    exp_count = exp_count + 8'd1;
    checks++; if (wr_en !== 1'b1 || wr_dst !== 4'd3 || wr_data !== 16'h1234)
      begin errors++; $display("FAIL alu_commit got %b/%h/%h want 1/3/1234", wr_en, wr_dst, wr_data); end
    checks++; if (wb_count !== 8'd1) begin errors++; $display("FAIL alu_count got %0d want 1", wb_count); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL alu_idle got %b want 0", wr_en); end
  endtask

  task automatic test_collision();
    mem_valid = 1; mem_dst = 4'd5; mem_data = 16'hAAAA;
    alu_valid = 1; alu_dst = 4'd6; alu_data = 16'h5555;
    tick();
    idle_inputs();
    exp_count = exp_count + 8'd1;
    checks++; if (wr_en !== 1'b1 || wr_dst !== 4'd5 || wr_data !== 16'hAAAA)
      begin errors++; $display("FAIL coll_mem got %b/%h/%h want 1/5/aaaa", wr_en, wr_dst, wr_data); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL coll_ready got %b want 0", alu_ready); end
    tick();
    exp_count = exp_count + 8'd1;
    checks++; if (wr_en !== 1'b1 || wr_dst !== 4'd6 || wr_data !== 16'h5555)
      begin errors++; $display("FAIL coll_hold got %b/%h/%h want 1/6/5555", wr_en, wr_dst, wr_data); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL coll_ready2 got %b want 1", alu_ready); end
    checks++; if (wb_count !== exp_count) begin errors++; $display("FAIL coll_count got %0d want %0d", wb_count, exp_count); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL coll_idle got %b want 0", wr_en); end
  endtask

  // Hold and loads share r2 so the hold value must be the last write.
  task automatic test_sustained_mem();
    mem_valid = 1; mem_dst = 4'd2; mem_data = 16'h1000;
    alu_valid = 1; alu_dst = 4'd2; alu_data = 16'h2222;
    tick();
    exp_count = exp_count + 8'd1;
    alu_data = 16'h9999; alu_dst = 4'd9;
    for (int i = 1; i <= 4; i++) begin
      mem_data = 16'h1000 + 16'(i);
      #1;
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL sus_ready[%0d] got %b want 0", i, alu_ready); end
      tick();
      exp_count = exp_count + 8'd1;
      checks++; if (wr_en !== 1'b1 || wr_dst !== 4'd2 || wr_data !== 16'h1000 + 16'(i))
        begin errors++; $display("FAIL sus_mem[%0d] got %b/%h/%h want 1/2/%h", i, wr_en, wr_dst, wr_data, 16'h1000 + 16'(i)); end
    end
    idle_inputs();
    tick();
    exp_count = exp_count + 8'd1;
    checks++; if (wr_en !== 1'b1 || wr_dst !== 4'd2 || wr_data !== 16'h2222)
      begin errors++; $display("FAIL sus_hold got %b/%h/%h want 1/2/2222", wr_en, wr_dst, wr_data); end
    checks++; if (wb_count !== exp_count) begin errors++; $display("FAIL sus_count got %0d want %0d", wb_count, exp_count); end
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL sus_idle got %b want 0", wr_en); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_dst = 4'd7;
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL sb_stall0 got %b want 0", issue_stall); end
    tick();
    checks++; if (busy !== 16'h0080) begin errors++; $display("FAIL sb_set got %h want 0080", busy); end
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL sb_stall1 got %b want 1", issue_stall); end
    issue_valid = 0;
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL sb_stall_novalid got %b want 0", issue_stall); end
    // Commit r7 while re-issuing: still stalled this cycle, bit clears.
    alu_valid = 1; alu_dst = 4'd7; alu_data = 16'h7777;
    issue_valid = 1; issue_dst = 4'd7;
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL sb_stall2 got %b want 1", issue_stall); end
    tick();
    exp_count = exp_count + 8'd1;
    checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL sb_clear got %h want 0000", busy); end
    // Bit now free: reservation coincides with another r7 commit and must win.
    alu_data = 16'h7778;
    tick();
    exp_count = exp_count + 8'd1;
    idle_inputs();
    checks++; if (busy !== 16'h0080) begin errors++; $display("FAIL sb_set_wins got %h want 0080", busy); end
    checks++; if (wr_en !== 1'b1 || wr_dst !== 4'd7 || wr_data !== 16'h7778)
      begin errors++; $display("FAIL sb_commit got %b/%h/%h want 1/7/7778", wr_en, wr_dst, wr_data); end
    mem_valid = 1; mem_dst = 4'd7; mem_data = 16'h0007;
    tick();
    exp_count = exp_count + 8'd1;
    idle_inputs();
    checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL sb_mem_clear got %h want 0000", busy); end
    checks++; if (wb_count !== exp_count) begin errors++; $display("FAIL sb_count got %0d want %0d", wb_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    for (int r = 4; r <= 7; r++) begin
      issue_valid = 1; issue_dst = 4'(r);
      tick();
    end
    idle_inputs();
    mem_valid = 1; mem_dst = 4'd1; mem_data = 16'h0101;
    alu_valid = 1; alu_dst = 4'd8; alu_data = 16'hBEEF;
    tick();
    idle_inputs();
    checks++; if (busy !== 16'h00F0) begin errors++; $display("FAIL rst_pre_busy got %h want 00f0", busy); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_hold got %b want 0", alu_ready); end
    #1;
    rst_n = 0;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_dst !== 4'd0 || wr_data !== 16'd0)
      begin errors++; $display("FAIL rst_async_wr got %b/%h/%h want 0/0/0", wr_en, wr_dst, wr_data); end
    checks++; if (busy !== 16'd0) begin errors++; $display("FAIL rst_async_busy got %h want 0", busy); end
    checks++; if (wb_count !== 8'd0) begin errors++; $display("FAIL rst_async_count got %0d want 0", wb_count); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got %b want 1", alu_ready); end
    tick();
    rst_n = 1;
    exp_count = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_no_hold_commit[%0d] got %b want 0", i, wr_en); end
    end
  endtask

  task automatic test_back_to_back();
    alu_valid = 1;
    for (int i = 0; i < 256; i++) begin
      alu_dst = 4'(i); alu_data = 16'(i * 3);
      tick();
      exp_count = exp_count + 8'd1;
      checks++; if (wr_en !== 1'b1 || wr_data !== 16'(i * 3))
        begin errors++; $display("FAIL b2b_commit[%0d] got %b/%h want 1/%h", i, wr_en, wr_data, 16'(i * 3)); end
      if (i == 254) begin
        checks++; if (wb_count !== 8'd255) begin errors++; $display("FAIL b2b_count255 got %0d want 255", wb_count); end
      end
    end
    idle_inputs();
    checks++; if (wb_count !== 8'd0) begin errors++; $display("FAIL b2b_wrap got %0d want 0", wb_count); end
    tick();
    checks++; if (wb_count !== 8'd0 || wr_en !== 1'b0)
      begin errors++; $display("FAIL b2b_idle got %0d/%b want 0/0", wb_count, wr_en); end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_collision();
    test_sustained_mem();
    test_scoreboard();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scalar_wb_arbiter.md
SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, writeback data width.
REQ-002 Parameter ADDR_W, default 4, register index width (2**ADDR_W = 16 registers).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 alu_valid  input  1  ALU result present.
REQ-006 alu_dst  input  ADDR_W  ALU destination register.
REQ-007 alu_data  input  DATA_W  ALU result.
REQ-008 alu_ready  output  1  ALU result accepted this cycle when high with alu_valid.
REQ-009 mem_valid  input  1  load result present; always accepted, never stalled.
REQ-010 mem_dst  input  ADDR_W  load destination register.
REQ-011 mem_data  input  DATA_W  load result.
REQ-012 issue_valid  input  1  decode issuing an instruction that writes issue_dst.
REQ-013 issue_dst  input  ADDR_W  destination being reserved.
REQ-014 issue_stall  output  1  issue refused (destination busy), combinational.
REQ-015 busy  output  2**ADDR_W  scoreboard, one pending-write bit per register.
REQ-016 wr_en  output  1  register file write enable, registered.
REQ-017 wr_dst  output  ADDR_W  register file write index, registered.
REQ-018 wr_data  output  DATA_W  register file write data, registered.
REQ-019 wb_count  output  8  committed-write counter.

Function
REQ-020 The block SHALL hold one ALU result in a holding register (hold_valid, hold_dst, hold_data).
REQ-021 alu_ready SHALL equal ~hold_valid; an ALU result is accepted when alu_valid && alu_ready.
REQ-022 Per-cycle selection, in priority order: mem_valid -> commit mem; else hold_valid -> commit hold and clear it; else accepted ALU -> commit ALU directly (bypass).
REQ-023 When mem_valid and an ALU result is accepted in the same cycle, the ALU result SHALL load the holding register and commit on a later cycle.
REQ-024 When mem_valid and hold_valid, the hold SHALL remain unchanged and alu_ready SHALL stay 0.
REQ-025 Commit latency SHALL be exactly one cycle: wr_en/wr_dst/wr_data reflect the source selected at the previous rising edge; wr_en = 0 when nothing is selected.
REQ-026 When hold and mem target the same register, mem SHALL commit first and hold next, so the hold value is final.
REQ-027 issue_stall SHALL equal issue_valid && busy[issue_dst].
REQ-028 On issue_valid && ~issue_stall, busy[issue_dst] SHALL be set at the next edge.
REQ-029 busy[d] SHALL clear on the edge that registers wr_en = 1 with wr_dst = d.
REQ-030 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-031 wb_count SHALL increment by 1 on each edge that registers wr_en = 1, wrapping 255 -> 0.
REQ-032 Results with no pending busy bit SHALL still commit; no error is flagged.

Reset
REQ-033 While rst_n = 0: wr_en = 0, wr_dst = 0, wr_data = 0, busy = 0, wb_count = 0, hold_valid = 0; alu_ready = 1.
REQ-034 Assertion mid-operation SHALL discard any held ALU result and all pending busy bits immediately, without waiting for a clock.
REQ-035 The first commit after reset release SHALL occur no earlier than one edge after a source is presented.

Verification
REQ-036 ALU only: alu_valid, dst 3, data 0x1234 -> next cycle wr_en = 1, wr_dst = 3, wr_data = 0x1234, wb_count = 1.
REQ-037 Collision: mem (5, 0xAAAA) and ALU (6, 0x5555) in one cycle -> cycle+1 writes r5 = 0xAAAA, cycle+2 writes r6 = 0x5555; alu_ready = 0 during cycle+1.
REQ-038 Sustained mem_valid for 4 cycles with hold full -> hold retained, alu_ready = 0 throughout, hold commits the cycle after mem_valid drops.
REQ-039 Scoreboard: issue r7 -> busy[7] = 1; re-issue r7 -> issue_stall = 1; commit r7 -> busy[7] = 0; reissue on the clearing edge -> busy[7] stays 1.
REQ-040 Reset pulse with hold full and busy = 0x00F0 -> outputs zero asynchronously, no commit of the held value after release.
REQ-041 256 back-to-back commits -> wb_count returns to 0.
